// File: rtl/axi_fifo_slv_pkg.sv
// Shared constants, state enums and address helpers for the AXI FIFO read slave.
package axi_fifo_slv_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] OFF_INT_STATUS = 32'h0000_0000;
  localparam logic [31:0] OFF_INT_MASK   = 32'h0000_0004;
  localparam logic [31:0] OFF_FIFO_BASE  = 32'h0000_0010;

  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {K_STATUS, K_MASK, K_FIFO, K_UNMAPPED} addr_kind_e;

  function automatic logic [31:0] fifo_addr(input int unsigned k);
    return OFF_FIFO_BASE + 32'(k) * 32'd4;
  endfunction

endpackage

// File: rtl/axi_fifo_slv_irq.sv
// Interrupt block: rising-edge capture into a W1C status register, RW mask,
// and a registered level interrupt.
module axi_fifo_slv_irq #(
  parameter int NUM_INT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_INT-1:0] i_int_src,
  input  logic [NUM_INT-1:0] i_status_clr,
  input  logic [NUM_INT-1:0] i_mask_wen,
  input  logic [NUM_INT-1:0] i_mask_wdata,
  output logic [NUM_INT-1:0] o_status,
  output logic [NUM_INT-1:0] o_mask,
  output logic               o_interrupt
);

  logic [NUM_INT-1:0] r_src_d;
  logic [NUM_INT-1:0] r_status;
  logic [NUM_INT-1:0] r_mask;
  logic               r_interrupt;
  logic [NUM_INT-1:0] w_set;

  assign w_set = i_int_src & ~r_src_d;

  // A new edge is OR-ed in after the clear so that it survives a same-cycle W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src_d     <= '0;
      r_status    <= '0;
      r_mask      <= '0;
      r_interrupt <= 1'b0;
    end else begin
      r_src_d     <= i_int_src;
      r_status    <= (r_status & ~i_status_clr) | w_set;
      r_mask      <= (r_mask & ~i_mask_wen) | (i_mask_wdata & i_mask_wen);
      r_interrupt <= |(r_status & r_mask);
    end
  end

  assign o_status    = r_status;
  assign o_mask      = r_mask;
  assign o_interrupt = r_interrupt;

endmodule

// File: rtl/axi_fifo_rd_slave_mc.sv
// AXI4 slave exposing show-ahead FIFO read ports plus an interrupt block.
// Build option AXI_FIFO_SLV_EMPTY_ERR_EN: empty-FIFO beats complete with SLVERR instead of stalling.
module axi_fifo_rd_slave_mc
  import axi_fifo_slv_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 12,
  parameter int                    NUM_FIFO   = 2,
  parameter int                    FIFO_WIDTH = 16,
  parameter int                    NUM_INT    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ID_WIDTH-1:0]            i_awid,
  input  logic [ADDR_WIDTH-1:0]          i_awaddr,
  input  logic [7:0]                     i_awlen,
  input  logic                           i_awvalid,
  output logic                           o_awready,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
  input  logic                           i_wlast,
  input  logic                           i_wvalid,
  output logic                           o_wready,
  output logic [ID_WIDTH-1:0]            o_bid,
  output logic [1:0]                     o_bresp,
  output logic                           o_bvalid,
  input  logic                           i_bready,
  input  logic [ID_WIDTH-1:0]            i_arid,
  input  logic [ADDR_WIDTH-1:0]          i_araddr,
  input  logic [7:0]                     i_arlen,
  input  logic                           i_arvalid,
  output logic                           o_arready,
  output logic [ID_WIDTH-1:0]            o_rid,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic [1:0]                     o_rresp,
  output logic                           o_rlast,
  output logic                           o_rvalid,
  input  logic                           i_rready,
  output logic [NUM_FIFO-1:0]            o_fifo_rd_en,
  input  logic [NUM_FIFO*FIFO_WIDTH-1:0] i_fifo_rd_data,
  input  logic [NUM_FIFO-1:0]            i_fifo_empty,
  input  logic [NUM_INT-1:0]             i_int_src,
  output logic                           o_interrupt
);

  typedef struct packed {
    addr_kind_e          kind;
    logic [NUM_FIFO-1:0] sel;
  } dec_t;

  function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    dec_t d;
    off    = a - BASE_ADDR;
    d.kind = K_UNMAPPED;
    d.sel  = '0;
    if (off == ADDR_WIDTH'(OFF_INT_STATUS)) d.kind = K_STATUS;
    else if (off == ADDR_WIDTH'(OFF_INT_MASK)) d.kind = K_MASK;
    else begin
      for (int k = 0; k < NUM_FIFO; k++) begin
        if (off == ADDR_WIDTH'(fifo_addr(k))) begin
          d.kind   = K_FIFO;
          d.sel[k] = 1'b1;
        end
      end
    end
    return d;
  endfunction

  rd_state_e             r_rstate, w_rstate_nxt;
  wr_state_e             r_wstate, w_wstate_nxt;
  logic [ID_WIDTH-1:0]   r_arid, r_awid;
  logic [ADDR_WIDTH-1:0] r_araddr, r_awaddr;
  logic [7:0]            r_arlen, r_cnt;
  logic [1:0]            r_bresp;
  dec_t                  w_rdec, w_wdec;
  logic [FIFO_WIDTH-1:0] w_head;
  logic                  w_sel_empty;
  logic [DATA_WIDTH-1:0] w_wbits;
  logic                  w_wbeat;
  logic [1:0]            w_beat_err;
  logic [NUM_INT-1:0]    w_status, w_mask, w_status_clr, w_mask_wen;
  logic                  w_unused;

  assign w_unused = ^i_awlen;
  assign w_rdec   = decode(r_araddr);
  assign w_wdec   = decode(r_awaddr);

  // ---------------- read path ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (i_arvalid) w_rstate_nxt = R_DATA;
      R_DATA:  if (o_rvalid && i_rready && o_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arid   <= '0;
      r_araddr <= '0;
      r_arlen  <= '0;
      r_cnt    <= '0;
    end else if (r_rstate == R_IDLE && i_arvalid) begin
      r_arid   <= i_arid;
      r_araddr <= i_araddr;
      r_arlen  <= i_arlen;
      r_cnt    <= '0;
    end else if (r_rstate == R_DATA && o_rvalid && i_rready) begin
      r_cnt    <= r_cnt + 8'd1;
    end
  end

  always_comb begin
    w_head      = '0;
    w_sel_empty = |(w_rdec.sel & i_fifo_empty);
    for (int k = 0; k < NUM_FIFO; k++) begin
      if (w_rdec.sel[k]) w_head = i_fifo_rd_data[k*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  // Register reads sample live state, so a read racing a W1C sees the pre-clear value.
  always_comb begin
    o_rvalid     = 1'b0;
    o_rdata      = '0;
    o_rresp      = RESP_OKAY;
    o_fifo_rd_en = '0;
    if (r_rstate == R_DATA) begin
      case (w_rdec.kind)
        K_STATUS: begin
          o_rvalid = 1'b1;
          o_rdata  = DATA_WIDTH'(w_status);
        end
        K_MASK: begin
          o_rvalid = 1'b1;
          o_rdata  = DATA_WIDTH'(w_mask);
        end
        K_FIFO: begin
`ifdef AXI_FIFO_SLV_EMPTY_ERR_EN
          o_rvalid = 1'b1;
          if (w_sel_empty) o_rresp = RESP_SLVERR;
          else begin
            o_rdata = DATA_WIDTH'(w_head);
            if (i_rready) o_fifo_rd_en = w_rdec.sel;
          end
`else
          o_rvalid = ~w_sel_empty;
          o_rdata  = DATA_WIDTH'(w_head);
          if (!w_sel_empty && i_rready) o_fifo_rd_en = w_rdec.sel;
`endif
        end
        default: begin
          o_rvalid = 1'b1;
          o_rresp  = RESP_DECERR;
        end
      endcase
    end
  end

  assign o_arready = (r_rstate == R_IDLE);
  assign o_rlast   = (r_rstate == R_DATA) && (r_cnt == r_arlen);
  assign o_rid     = r_arid;

  // ---------------- write path ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (i_awvalid) w_wstate_nxt = W_DATA;
      W_DATA:  if (i_wvalid && i_wlast) w_wstate_nxt = W_RESP;
      W_RESP:  if (i_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    o_awready = (r_wstate == W_IDLE);
    o_wready  = (r_wstate == W_DATA);
    o_bvalid  = (r_wstate == W_RESP);
  end

  always_comb begin
    for (int i = 0; i < DATA_WIDTH; i++) w_wbits[i] = i_wstrb[i/8];
  end

  assign w_wbeat      = (r_wstate == W_DATA) && i_wvalid;
  assign w_status_clr = (w_wbeat && w_wdec.kind == K_STATUS) ? NUM_INT'(i_wdata & w_wbits) : '0;
  assign w_mask_wen   = (w_wbeat && w_wdec.kind == K_MASK) ? NUM_INT'(w_wbits) : '0;

  always_comb begin
    case (w_wdec.kind)
      K_FIFO:     w_beat_err = RESP_SLVERR;
      K_UNMAPPED: w_beat_err = RESP_DECERR;
      default:    w_beat_err = RESP_OKAY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_awid   <= '0;
      r_awaddr <= '0;
      r_bresp  <= RESP_OKAY;
    end else if (r_wstate == W_IDLE && i_awvalid) begin
      r_awid   <= i_awid;
      r_awaddr <= i_awaddr;
      r_bresp  <= RESP_OKAY;
    end else if (w_wbeat && w_beat_err != RESP_OKAY) begin
      r_bresp  <= w_beat_err;
    end
  end

  assign o_bid   = r_awid;
  assign o_bresp = r_bresp;

  axi_fifo_slv_irq #(.NUM_INT(NUM_INT)) u_irq (
    .clk          (clk),
    .rst          (rst),
    .i_int_src    (i_int_src),
    .i_status_clr (w_status_clr),
    .i_mask_wen   (w_mask_wen),
    .i_mask_wdata (NUM_INT'(i_wdata)),
    .o_status     (w_status),
    .o_mask       (w_mask),
    .o_interrupt  (o_interrupt)
  );

endmodule

// File: tb/tb_axi_fifo_rd_slave_mc.sv
// Directed self-checking bench for axi_fifo_rd_slave_mc with a queue model of the two FIFOs.
// Follows the AXI_FIFO_SLV_EMPTY_ERR_EN build option for the empty-FIFO scenario.
module tb_axi_fifo_rd_slave_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready, interrupt;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [1:0]  fifoRdEn, fifoEmpty;
  logic [31:0] fifoRdData;
  logic [7:0]  intSrc;

  int checkCount = 0;
  int errorCount = 0;

  logic [15:0] q0[$], q1[$];
  int          popCount0 = 0, popCount1 = 0, popViolation = 0;

  logic        sRvalid, sRready, sRlast, sBvalid, sInt;
  logic [31:0] sRdata;
  logic [1:0]  sRresp, sBresp, sRdEn;
  logic [11:0] sRid, sBid;

  logic [31:0] bData[$];
  logic [1:0]  bResp[$];
  logic        bLast[$];
  int          beatsAtPush, ridErr;
  bit          timedOut;

  always #5 clk = ~clk;

  axi_fifo_rd_slave_mc dut (
    .clk(clk), .rst(rst),
    .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awvalid(awvalid), .o_awready(awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
    .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
    .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arvalid(arvalid), .o_arready(arready),
    .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid), .i_rready(rready),
    .o_fifo_rd_en(fifoRdEn), .i_fifo_rd_data(fifoRdData), .i_fifo_empty(fifoEmpty),
    .i_int_src(intSrc), .o_interrupt(interrupt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic refreshFifo();
    fifoEmpty[0] = (q0.size() == 0);
    fifoEmpty[1] = (q1.size() == 0);
    fifoRdData[15:0]  = (q0.size() != 0) ? q0[0] : 16'h0;
    fifoRdData[31:16] = (q1.size() != 0) ? q1[0] : 16'h0;
  endtask

  // Sample at the falling edge, let the FIFO model pop at the rising edge, then drive.
  task automatic stepCycle();
    @(negedge clk);
    sRvalid = rvalid; sRready = rready; sRdata = rdata; sRresp = rresp; sRlast = rlast;
    sRid = rid; sRdEn = fifoRdEn; sBvalid = bvalid; sBresp = bresp; sBid = bid; sInt = interrupt;
    if (sRdEn != 2'b00 && !(sRvalid && sRready)) popViolation++;
    @(posedge clk);
    if (sRdEn[0] && q0.size() != 0) begin void'(q0.pop_front()); popCount0++; end
    if (sRdEn[1] && q1.size() != 0) begin void'(q1.pop_front()); popCount1++; end
    #1;
    refreshFifo();
  endtask

  function automatic logic [31:0] beatData(input int i);
    return (i < bData.size()) ? bData[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [1:0] beatResp(input int i);
    return (i < bResp.size()) ? bResp[i] : 2'b01;
  endfunction

  function automatic logic [7:0] lastPattern();
    logic [7:0] p = '0;
    for (int i = 0; i < bLast.size() && i < 8; i++) p[i] = bLast[i];
    return p;
  endfunction

  task automatic doRead(input logic [31:0] addr, input logic [7:0] len, input bit toggle, input int pushAt);
    bit done = 0;
    bData.delete(); bResp.delete(); bLast.delete();
    timedOut = 0; beatsAtPush = -1; ridErr = 0;
    araddr = addr; arlen = len; arid = 12'h05A; arvalid = 1'b1;
    stepCycle();
    arvalid = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (cyc == pushAt) begin
        beatsAtPush = bData.size();
        q0.push_back(16'h00A1);
        q0.push_back(16'h00A2);
        refreshFifo();
      end
      rready = toggle ? (cyc % 2 == 0) : 1'b1;
      stepCycle();
      if (sRvalid && sRready) begin
        bData.push_back(sRdata);
        bResp.push_back(sRresp);
        bLast.push_back(sRlast);
        if (sRid != 12'h05A) ridErr++;
        if (sRlast) done = 1;
      end
    end
    rready = 1'b0;
    timedOut = !done;
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input bit pulseSrc, output logic [1:0] resp, output logic [11:0] id);
    bit got = 0;
    resp = 2'b01;
    id = '0;
    awaddr = addr; awid = 12'h03C; awlen = 8'd0; awvalid = 1'b1;
    stepCycle();
    awvalid = 1'b0;
    wdata = data; wstrb = strb; wlast = 1'b1; wvalid = 1'b1;
    if (pulseSrc) intSrc[0] = 1'b1;
    stepCycle();
    wvalid = 1'b0; wlast = 1'b0; intSrc[0] = 1'b0;
    bready = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      stepCycle();
      if (sBvalid) begin resp = sBresp; id = sBid; got = 1; end
    end
    bready = 1'b0;
  endtask

  task automatic applyStimulus();
    logic [1:0]  resp;
    logic [11:0] id;
    int          p0, p1;

    // Reset state
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 0; wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 0; rready = 0; intSrc = '0;
    refreshFifo();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_arready", arready, 1);
    checkOutput("rst_awready", awready, 1);
    checkOutput("rst_outs", {rvalid, wready, bvalid, interrupt, rlast, fifoRdEn}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1 plain FIFO1 burst
    for (int i = 1; i <= 4; i++) q1.push_back(16'(i));
    refreshFifo();
    p1 = popCount1;
    doRead(32'h4000_0014, 8'd3, 0, -1);
    checkOutput("t1_timeout", timedOut, 0);
    checkOutput("t1_beats", bData.size(), 4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t1_data%0d", i), beatData(i), i + 1);
    checkOutput("t1_resp", {beatResp(0), beatResp(1), beatResp(2), beatResp(3)}, 0);
    checkOutput("t1_last", lastPattern(), 8'b0000_1000);
    checkOutput("t1_pops", popCount1 - p1, 4);
    checkOutput("t1_rid", ridErr, 0);

    // T2 same burst with rready toggling
    for (int i = 5; i <= 8; i++) q1.push_back(16'(i));
    refreshFifo();
    p1 = popCount1;
    popViolation = 0;
    doRead(32'h4000_0014, 8'd3, 1, -1);
    checkOutput("t2_beats", bData.size(), 4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t2_data%0d", i), beatData(i), i + 5);
    checkOutput("t2_last", lastPattern(), 8'b0000_1000);
    checkOutput("t2_pops", popCount1 - p1, 4);
    checkOutput("t2_popWithoutHs", popViolation, 0);

    // T3 interrupt set, registered latency, W1C clear
    doWrite(32'h4000_0004, 32'h0000_0001, 4'hF, 0, resp, id);
    checkOutput("t3_maskResp", resp, 2'b00);
    checkOutput("t3_bid", id, 12'h03C);
    stepCycle();
    checkOutput("t3_intIdle", sInt, 0);
    intSrc[0] = 1'b1;
    stepCycle();
    intSrc[0] = 1'b0;
    stepCycle();
    checkOutput("t3_intLatency", sInt, 0);
    stepCycle();
    checkOutput("t3_intSet", sInt, 1);
    doRead(32'h4000_0000, 8'd0, 0, -1);
    checkOutput("t3_status", beatData(0), 32'h1);
    checkOutput("t3_statusLast", lastPattern(), 8'b1);
    doWrite(32'h4000_0000, 32'h0000_0001, 4'hF, 0, resp, id);
    checkOutput("t3_clrResp", resp, 2'b00);
    stepCycle(); stepCycle();
    checkOutput("t3_intClr", sInt, 0);
    doRead(32'h4000_0000, 8'd0, 0, -1);
    checkOutput("t3_statusClr", beatData(0), 32'h0);

    // Zero strobes leave the mask untouched
    doWrite(32'h4000_0004, 32'h0000_0000, 4'h0, 0, resp, id);
    doRead(32'h4000_0004, 8'd0, 0, -1);
    checkOutput("mask_noStrb", beatData(0), 32'h1);

    // T4 set and W1C in the same cycle
    doWrite(32'h4000_0000, 32'h0000_0001, 4'hF, 1, resp, id);
    doRead(32'h4000_0000, 8'd0, 0, -1);
    checkOutput("t4_setWins", beatData(0), 32'h1);
    checkOutput("t4_int", sInt, 1);

    // T5 error responses
    p1 = popCount1;
    q1.push_back(16'h0077);
    refreshFifo();
    doWrite(32'h4000_0014, 32'hFFFF_FFFF, 4'hF, 0, resp, id);
    checkOutput("t5_fifoWr", resp, 2'b10);
    checkOutput("t5_fifoWrNoPop", popCount1 - p1, 0);
    doWrite(32'h4000_0100, 32'h0, 4'hF, 0, resp, id);
    checkOutput("t5_unmappedWr", resp, 2'b11);
    doRead(32'h4000_0040, 8'd1, 0, -1);
    checkOutput("t5_beats", bData.size(), 2);
    checkOutput("t5_resp", {beatResp(0), beatResp(1)}, 4'b1111);
    checkOutput("t5_data", {beatData(0), beatData(1)}, 64'h0);
    checkOutput("t5_last", lastPattern(), 8'b10);
    doRead(32'h4000_0014, 8'd0, 0, -1);
    checkOutput("t5_fifoKept", beatData(0), 32'h77);

    // T6 empty FIFO0
    p0 = popCount0;
`ifdef AXI_FIFO_SLV_EMPTY_ERR_EN
    doRead(32'h4000_0010, 8'd1, 0, -1);
    checkOutput("t6_errBeats", bData.size(), 2);
    checkOutput("t6_errResp", {beatResp(0), beatResp(1)}, 4'b1010);
    checkOutput("t6_errData", {beatData(0), beatData(1)}, 64'h0);
    checkOutput("t6_errPops", popCount0 - p0, 0);
    doRead(32'h4000_0010, 8'd1, 0, 0);
`else
    doRead(32'h4000_0010, 8'd1, 0, 20);
    checkOutput("t6_stall", beatsAtPush, 0);
`endif
    checkOutput("t6_beats", bData.size(), 2);
    checkOutput("t6_resp", {beatResp(0), beatResp(1)}, 4'b0000);
    checkOutput("t6_data0", beatData(0), 32'hA1);
    checkOutput("t6_data1", beatData(1), 32'hA2);
    checkOutput("t6_pops", popCount0 - p0, 2);
  endtask

  initial begin
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
